// File: rtl/fixed_mult_pipe_if.sv
// fixed_mult_pipe_if: operand/result valid-ready bundle for the pipelined fixed-point multiplier.
interface fixed_mult_pipe_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             overflow;
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, c, overflow);
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, c, overflow);
endinterface

// File: rtl/fixed_mult_pipe.sv
// fixed_mult_pipe: pipelined signed fixed-point multiplier, sign-magnitude core with rounding/saturation.
module fixed_mult_pipe #(
  parameter int WIDTH    = 64,
  parameter int FRAC     = 32,
  parameter int STAGES   = 3,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input logic             clk,
  input logic             rst,
  fixed_mult_pipe_if.slave io_bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int LO = WIDTH / 2;
  localparam int DN = STAGES - 2;
  localparam logic [W2-1:0] ONE = {{(W2-1){1'b0}}, 1'b1};
  localparam logic [W2-1:0] HALF = (ROUND != 0) ? (ONE << (FRAC - 1)) : '0;
  localparam logic [W2-1:0] NEG_LIM = ONE << (WIDTH - 1);
  localparam logic [W2-1:0] POS_LIM = NEG_LIM - ONE;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;
  logic             w_en;
  logic [WIDTH-1:0] w_ma, w_mb, w_mag, w_c;
  logic [W2-1:0]    w_ah, w_al, w_bh, w_bl, w_p, w_m;
  logic             w_ovf;
  logic             r_v1, r_s1, r_v2, r_s2;
  logic [WIDTH-1:0] r_ma, r_mb;
  logic [W2-1:0]    r_hh, r_hl, r_lh, r_ll;
  logic             r_vd [DN];
  logic             r_od [DN];
  logic [WIDTH-1:0] r_cd [DN];
  // a single global enable: the whole pipe freezes while the output is held
  assign w_en = !io_bus.out_valid || io_bus.out_ready;
  assign io_bus.in_ready = w_en;
  assign io_bus.out_valid = r_vd[DN-1];
  assign io_bus.c = r_cd[DN-1];
  assign io_bus.overflow = r_od[DN-1];
  assign w_ma = io_bus.a[WIDTH-1] ? -io_bus.a : io_bus.a;
  assign w_mb = io_bus.b[WIDTH-1] ? -io_bus.b : io_bus.b;
  assign w_ah = W2'(r_ma[WIDTH-1:LO]);
  assign w_al = W2'(r_ma[LO-1:0]);
  assign w_bh = W2'(r_mb[WIDTH-1:LO]);
  assign w_bl = W2'(r_mb[LO-1:0]);
  assign w_p = (r_hh << (2 * LO)) + ((r_hl + r_lh) << LO) + r_ll + HALF;
  assign w_m = w_p >> FRAC;
  assign w_ovf = r_s2 ? (w_m > NEG_LIM) : (w_m > POS_LIM);
  assign w_mag = w_m[WIDTH-1:0];
  // negating a zero magnitude yields zero, so no -0 can escape
  assign w_c = (SATURATE != 0 && w_ovf) ? (r_s2 ? SMIN : SMAX) : (r_s2 ? -w_mag : w_mag);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_s1 <= 1'b0;
      r_ma <= '0;
      r_mb <= '0;
      r_v2 <= 1'b0;
      r_s2 <= 1'b0;
      r_hh <= '0;
      r_hl <= '0;
      r_lh <= '0;
      r_ll <= '0;
      for (int k = 0; k < DN; k++) begin
        r_vd[k] <= 1'b0;
        r_od[k] <= 1'b0;
        r_cd[k] <= '0;
      end
    end else if (w_en) begin
      r_v1 <= io_bus.in_valid;
      r_s1 <= io_bus.a[WIDTH-1] ^ io_bus.b[WIDTH-1];
      r_ma <= w_ma;
      r_mb <= w_mb;
      r_v2 <= r_v1;
      r_s2 <= r_s1;
      r_hh <= w_ah * w_bh;
      r_hl <= w_ah * w_bl;
      r_lh <= w_al * w_bh;
      r_ll <= w_al * w_bl;
      r_vd[0] <= r_v2;
      r_od[0] <= r_v2 && w_ovf;
      r_cd[0] <= r_v2 ? w_c : '0;
      for (int k = 1; k < DN; k++) begin
        r_vd[k] <= r_vd[k-1];
        r_od[k] <= r_od[k-1];
        r_cd[k] <= r_cd[k-1];
      end
    end
  end
endmodule

// File: tb/tb_fixed_mult_pipe.sv
// tb_fixed_mult_pipe: random and directed stimulus on two multiplier builds against a queue-based arithmetic model.
module tb_fixed_mult_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fixed_mult_pipe_if #(.WIDTH(64)) bus0 ();
  fixed_mult_pipe_if #(.WIDTH(64)) bus1 ();
  assign bus1.in_valid = bus0.in_valid;
  assign bus1.a = bus0.a;
  assign bus1.b = bus0.b;
  assign bus1.out_ready = bus0.out_ready;
  fixed_mult_pipe #(.WIDTH(64), .FRAC(32), .STAGES(3), .ROUND(1), .SATURATE(1)) dut0 (
    .clk(clk), .rst(rst), .io_bus(bus0.slave));
  fixed_mult_pipe #(.WIDTH(64), .FRAC(32), .STAGES(3), .ROUND(0), .SATURATE(0)) dut1 (
    .clk(clk), .rst(rst), .io_bus(bus1.slave));
  int total = 0;
  int bad = 0;
  logic [64:0] q [2][$];
  logic        hold [2];
  logic [63:0] hc [2];
  logic        rdone;
  task automatic chk(input string n, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  // {overflow, c} from exact signed product, rounding and clamping applied to the magnitude
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input bit rnd, input bit sat);
    logic signed [127:0] p;
    logic [127:0] m;
    logic s, ovf;
    logic [63:0] c;
    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    s = a[63] ^ b[63];
    m = p[127] ? -p : p;
    m = (m + (rnd ? 128'h8000_0000 : 128'h0)) >> 32;
    ovf = s ? (m > 128'h8000_0000_0000_0000) : (m > 128'h7FFF_FFFF_FFFF_FFFF);
    c = (sat && ovf) ? (s ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF) : (s ? -m[63:0] : m[63:0]);
    return {ovf, c};
  endfunction
  task automatic mon(input int k, input logic iv, input logic ir, input logic ov, input logic ordy,
                     input logic ovf, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [64:0] e;
    if (ov && q[k].size() == 0) chk($sformatf("spurious_valid%0d", k), 65'(ov), 65'(0));
    else if (ov && ordy) begin
      e = q[k].pop_front();
      chk($sformatf("c%0d", k), 65'(c), 65'(e[63:0]));
      chk($sformatf("ovf%0d", k), 65'(ovf), 65'(e[64]));
    end
    if (ov && hold[k]) chk($sformatf("stable_c%0d", k), 65'(c), 65'(hc[k]));
    chk($sformatf("in_ready%0d", k), 65'(ir), 65'(!(ov && !ordy)));
    hold[k] = ov && !ordy;
    hc[k] = c;
    if (iv && ir) q[k].push_back(model(a, b, k == 0, k == 0));
  endtask
  always @(negedge clk) begin
    if (rst) begin
      q[0].delete();
      q[1].delete();
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      mon(0, bus0.in_valid, bus0.in_ready, bus0.out_valid, bus0.out_ready, bus0.overflow, bus0.a, bus0.b, bus0.c);
      mon(1, bus1.in_valid, bus1.in_ready, bus1.out_valid, bus1.out_ready, bus1.overflow, bus1.a, bus1.b, bus1.c);
    end
  end
  task automatic send(input logic [63:0] a, input logic [63:0] b);
    int g;
    bus0.in_valid = 1'b1;
    bus0.a = a;
    bus0.b = b;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus0.in_ready && g < 100);
    if (g >= 100) chk("send_timeout", 65'(bus0.in_ready), 65'(1));
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
  endtask
  task automatic drain();
    int g;
    bus0.out_ready = 1'b1;
    g = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 65'(q[0].size() + q[1].size()), 65'(0));
  endtask
  function automatic logic [63:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return r;
      1: return {{24{r[39]}}, r[39:0]};
      2: return {{16{r[47]}}, r[47:0]};
      default: begin
        case ($urandom_range(0, 5))
          0: return 64'h8000_0000_0000_0000;
          1: return 64'h7FFF_FFFF_FFFF_FFFF;
          2: return 64'h0;
          3: return 64'hFFFF_FFFF_FFFF_FFFF;
          4: return 64'h0000_0001_0000_0000;
          default: return 64'hFFFF_FFFF_0000_0000;
        endcase
      end
    endcase
  endfunction
  logic [63:0] da [8] = '{64'h0000_0001_8000_0000, 64'hFFFF_FFFE_8000_0000, 64'hFFFF_FFFE_8000_0000,
                          64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0010_0000_0000_0000,
                          64'h8000_0000_0000_0000, 64'h0};
  logic [63:0] db [8] = '{64'h0000_0002_0000_0000, 64'h0000_0002_0000_0000, 64'hFFFF_FFFE_0000_0000,
                          64'h8000_0000, 64'h8000_0000, 64'h0010_0000_0000_0000,
                          64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000};
  initial begin
    int lat;
    bus0.in_valid = 1'b0;
    bus0.a = '0;
    bus0.b = '0;
    bus0.out_ready = 1'b1;
    rdone = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid0", 65'(bus0.out_valid), 65'(0));
    chk("rst_c0", 65'(bus0.c), 65'(0));
    chk("rst_ovf0", 65'(bus0.overflow), 65'(0));
    chk("rst_in_ready0", 65'(bus0.in_ready), 65'(1));
    chk("rst_out_valid1", 65'(bus1.out_valid), 65'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    chk("pin_mul", model(64'h0000_0001_8000_0000, 64'h0000_0002_0000_0000, 1, 1), {1'b0, 64'h0000_0003_0000_0000});
    chk("pin_neg", model(64'hFFFF_FFFE_8000_0000, 64'h0000_0002_0000_0000, 1, 1), {1'b0, 64'hFFFF_FFFD_0000_0000});
    chk("pin_negneg", model(64'hFFFF_FFFE_8000_0000, 64'hFFFF_FFFE_0000_0000, 1, 1), {1'b0, 64'h0000_0003_0000_0000});
    chk("pin_trunc", model(64'h1, 64'h8000_0000, 0, 1), {1'b0, 64'h0});
    chk("pin_round", model(64'h1, 64'h8000_0000, 1, 1), {1'b0, 64'h1});
    chk("pin_trunc_neg", model(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 0, 1), {1'b0, 64'h0});
    chk("pin_round_neg", model(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 1, 1), {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    chk("pin_sat", model(64'h0010_0000_0000_0000, 64'h0010_0000_0000_0000, 1, 1), {1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    chk("pin_wrap", model(64'h0010_0000_0000_0000, 64'h0010_0000_0000_0000, 0, 0), {1'b1, 64'h0});
    chk("pin_minint", model(64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, 1, 1), {1'b0, 64'h8000_0000_0000_0000});
    send(64'h0000_0001_8000_0000, 64'h0000_0002_0000_0000);
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 65'(lat), 65'(3));
    chk("lat_c", 65'(bus0.c), 65'(64'h0000_0003_0000_0000));
    drain();
    for (int i = 0; i < 8; i++) send(da[i], db[i]);
    drain();
    fork
      for (int i = 0; i < 8; i++) send(64'(i + 1) << 32, 64'h0000_0002_8000_0000);
      begin
        repeat (4) @(posedge clk);
        #1 bus0.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus0.out_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 3; i++) send(64'(i + 3) << 32, 64'hFFFF_FFFF_4000_0000);
    rst = 1'b1;
    #1;
    chk("midrst_valid0", 65'(bus0.out_valid), 65'(0));
    chk("midrst_c0", 65'(bus0.c), 65'(0));
    chk("midrst_valid1", 65'(bus1.out_valid), 65'(0));
    chk("midrst_c1", 65'(bus1.c), 65'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 400; i++) send(rnd_op(), rnd_op());
        rdone = 1'b1;
      end
      while (!rdone) begin
        @(posedge clk);
        #1 bus0.out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
